// File: rtl/feature_read_ctrl.sv
// Feature-buffer read controller: walks W lines of W words out of ping-pong line
// buffers and flags the deliveries that complete a KxK convolution window.
`ifndef Tn
`define Tn 8
`endif
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 5
`endif

module feature_read_ctrl #(
   parameter int Tn            = `Tn,
   parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
   parameter int KERNEL_SIZE   = `KERNEL_SIZE,
   parameter int ADDR_WIDTH    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            current_kernel_size,
   input  logic [7:0]            feature_size,
   input  logic [1:0]            buf_ready,
   output logic [1:0]            buf_release,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   output logic                  input_buffer_select,
   output logic                  line_buffer_enable,
   output logic                  window_valid,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_BUF, S_READ, S_RELEASE, S_FINISH
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] w_q, w_d;
   logic [2:0] k_q, k_d;
   logic [7:0] line_cnt_q, line_cnt_d;
   logic [7:0] col_cnt_q, col_cnt_d;
   logic       rd_buf_q, rd_buf_d;
   logic       lbe_q, ibs_q, win_q, win_d;
   logic [7:0] w_m1, k_m1;

   // Word-width / kernel-limit parameters only size the datapath outside this block.
   logic unused_params;
   assign unused_params = (Tn > 0) ^ (FEATURE_WIDTH > 0) ^ (KERNEL_SIZE > 0);

   assign w_m1 = w_q - 8'd1;
   assign k_m1 = {5'd0, k_q} - 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         w_q        <= '0;
         k_q        <= '0;
         line_cnt_q <= '0;
         col_cnt_q  <= '0;
         rd_buf_q   <= 1'b0;
         lbe_q      <= 1'b0;
         ibs_q      <= 1'b0;
         win_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         k_q        <= k_d;
         line_cnt_q <= line_cnt_d;
         col_cnt_q  <= col_cnt_d;
         rd_buf_q   <= rd_buf_d;
         lbe_q      <= mem_rd_en;
         ibs_q      <= rd_buf_q;
         win_q      <= win_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      k_d         = k_q;
      line_cnt_d  = line_cnt_q;
      col_cnt_d   = col_cnt_q;
      rd_buf_d    = rd_buf_q;
      win_d       = 1'b0;
      buf_release = 2'b00;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      done        = 1'b0;
      busy        = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               w_d        = feature_size;
               k_d        = current_kernel_size;
               line_cnt_d = '0;
               col_cnt_d  = '0;
               rd_buf_d   = 1'b0;
               // Degenerate pass: nothing to read, just signal completion.
               if (feature_size == 8'd0 || current_kernel_size == 3'd0) state_d = S_FINISH;
               else                                                   state_d = S_WAIT_BUF;
            end
         end
         S_WAIT_BUF: begin
            if (buf_ready[rd_buf_q]) begin
               col_cnt_d = '0;
               state_d   = S_READ;
            end
         end
         S_READ: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = ADDR_WIDTH'(col_cnt_q);
            // Tagged now, presented one cycle later alongside the read data.
            win_d       = (line_cnt_q >= k_m1) && (col_cnt_q >= k_m1);
            if (col_cnt_q == w_m1) state_d = S_RELEASE;
            else                   col_cnt_d = col_cnt_q + 8'd1;
         end
         S_RELEASE: begin
            buf_release[rd_buf_q] = 1'b1;
            rd_buf_d   = ~rd_buf_q;
            line_cnt_d = line_cnt_q + 8'd1;
            if (line_cnt_d == w_q) state_d = S_FINISH;
            else                   state_d = S_WAIT_BUF;
         end
         S_FINISH: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign line_buffer_enable  = lbe_q;
   assign input_buffer_select = ibs_q;
   assign window_valid        = win_q;

endmodule

// File: tb/tb_feature_read_ctrl.sv
// Randomized bench for feature_read_ctrl, scored against a sequence-level model
// of the pass (read addresses, delivered words, releases, done).
module tb_feature_read_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, start;
   logic [2:0] cks;
   logic [7:0] fsz;
   logic [1:0] buf_ready;
   logic [1:0] buf_release;
   logic       mem_rd_en;
   logic [7:0] mem_rd_addr;
   logic       input_buffer_select, line_buffer_enable, window_valid, busy, done;

   int tests = 0, fails = 0;
   int rdy_mode = 0;
   logic [1:0] rdy_fixed = 2'b11;

   bit         mon_en = 0;
   int         cyc = 0;
   int         rd_addrs[$];
   int         rd_cycs[$];
   logic [1:0] dlv[$];
   logic [1:0] rels[$];
   int         done_cnt, orphan_wv, last_rel_cyc, done_cyc;

   feature_read_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .current_kernel_size(cks),
      .feature_size(fsz), .buf_ready(buf_ready), .buf_release(buf_release),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .input_buffer_select(input_buffer_select), .line_buffer_enable(line_buffer_enable),
      .window_valid(window_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      #1;
      buf_ready = (rdy_mode != 0) ? 2'($urandom) : rdy_fixed;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_rd_en) begin
            rd_addrs.push_back(int'(mem_rd_addr));
            rd_cycs.push_back(cyc);
         end
         if (line_buffer_enable) dlv.push_back({input_buffer_select, window_valid});
         if (window_valid && !line_buffer_enable) orphan_wv++;
         if (buf_release != 2'b00) begin
            rels.push_back(buf_release);
            last_rel_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic clear_mon();
      rd_addrs.delete(); rd_cycs.delete(); dlv.delete(); rels.delete();
      done_cnt = 0; orphan_wv = 0; last_rel_cyc = -1; done_cyc = -1;
   endtask

   // Runs one pass and scores the observed streams against the pass model:
   // read i -> addr i%W; delivery i -> line i/W, col i%W, buffer line%2,
   // window when line>=k-1 and col>=k-1; releases alternate buffer 0,1,...
   task automatic run_pass(input int w, input int k, input int mode,
                           output int n_rd, output int bad_rd, output int bubbles,
                           output int n_dl, output int bad_dl, output int n_wv,
                           output int n_rel, output int bad_rel, output int n_done,
                           output int timed_out);
      @(negedge clk);
      clear_mon();
      mon_en = 1; rdy_mode = mode; rdy_fixed = 2'b11;
      fsz = 8'(w); cks = 3'(k); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      timed_out = 1;
      for (int c = 0; c < 6000; c++) begin
         if (done) begin timed_out = 0; break; end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      mon_en = 0; rdy_mode = 0;
      n_rd = rd_addrs.size(); bad_rd = 0; bubbles = 0;
      n_dl = dlv.size(); bad_dl = orphan_wv; n_wv = 0;
      n_rel = rels.size(); bad_rel = 0; n_done = done_cnt;
      for (int i = 0; i < n_rd; i++) begin
         if (w == 0 || rd_addrs[i] != i % w) bad_rd++;
         if (w > 0 && i % w != 0 && rd_cycs[i] != rd_cycs[i-1] + 1) bubbles++;
      end
      for (int i = 0; i < n_dl; i++) begin
         int ln, cl;
         logic ew;
         ln = (w > 0) ? i / w : 0;
         cl = (w > 0) ? i % w : 0;
         ew = (ln >= k - 1) && (cl >= k - 1);
         if (dlv[i][0]) n_wv++;
         if (dlv[i] !== {1'(ln % 2), ew}) bad_dl++;
      end
      for (int i = 0; i < n_rel; i++)
         if (rels[i] !== ((i % 2 == 1) ? 2'b10 : 2'b01)) bad_rel++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; fsz = 8'd0; cks = 3'd0;
      #12;
      tests++;
      if ({buf_release, mem_rd_en, mem_rd_addr, input_buffer_select, line_buffer_enable,
           window_valid, busy, done} !== 16'd0) begin
         fails++;
         $display("FAIL reset_outputs: got rel=%b rd=%b addr=%0d ibs=%b lbe=%b wv=%b busy=%b done=%b, want all 0",
                  buf_release, mem_rd_en, mem_rd_addr, input_buffer_select, line_buffer_enable,
                  window_valid, busy, done);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_full_pass(input string nm, input int w, input int k, input int mode,
                                 input int exp_wv);
      int n_rd, bad_rd, bub, n_dl, bad_dl, n_wv, n_rel, bad_rel, n_done, to;
      int er;
      run_pass(w, k, mode, n_rd, bad_rd, bub, n_dl, bad_dl, n_wv, n_rel, bad_rel, n_done, to);
      er = (w > 0 && k > 0) ? w * w : 0;
      tests++;
      if (to != 0) begin fails++; $display("FAIL %s_timeout: no done within budget", nm); end
      tests++;
      if (n_rd != er || bad_rd != 0 || bub != 0) begin
         fails++;
         $display("FAIL %s_reads: got %0d reads (%0d bad addr, %0d bubbles), want %0d clean", nm, n_rd, bad_rd, bub, er);
      end
      tests++;
      if (n_dl != er || bad_dl != 0) begin
         fails++;
         $display("FAIL %s_deliver: got %0d words (%0d wrong sel/window), want %0d clean", nm, n_dl, bad_dl, er);
      end
      if (exp_wv >= 0) begin
         tests++;
         if (n_wv != exp_wv) begin fails++; $display("FAIL %s_wv_count: got %0d want %0d", nm, n_wv, exp_wv); end
      end
      tests++;
      if (n_rel != ((k > 0) ? w : 0) || bad_rel != 0 || n_done != 1) begin
         fails++;
         $display("FAIL %s_release_done: got %0d releases (%0d bad), %0d done; want %0d, 0, 1",
                  nm, n_rel, bad_rel, n_done, (k > 0) ? w : 0);
      end
      if (er > 0) begin
         tests++;
         if (done_cyc != last_rel_cyc + 1) begin
            fails++;
            $display("FAIL %s_done_timing: done at %0d, last release at %0d, want +1", nm, done_cyc, last_rel_cyc);
         end
      end
   endtask

   task automatic test_random_ready();
      for (int it = 0; it < 4; it++) begin
         int w, k;
         w = int'($urandom_range(1, 8));
         k = int'($urandom_range(1, 6));
         test_full_pass($sformatf("rand%0d_w%0d_k%0d", it, w, k), w, k, 1, -1);
      end
   endtask

   task automatic test_stall();
      int bad, to;
      @(negedge clk);
      rdy_mode = 0; rdy_fixed = 2'b01; fsz = 8'd4; cks = 3'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      to = 1;
      for (int c = 0; c < 100; c++) begin
         if (buf_release == 2'b01) begin to = 0; break; end
         @(negedge clk);
      end
      tests++;
      if (to != 0) begin fails++; $display("FAIL stall_line0_release: not seen within budget"); end
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (mem_rd_en !== 1'b0 || busy !== 1'b1) bad++;
      end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL stall_wait: %0d cycles read or idle while buffer 1 unready, want 0", bad); end
      rdy_fixed = 2'b11;
      @(negedge clk);
      tests++;
      if (mem_rd_en !== 1'b1 || mem_rd_addr !== 8'd0) begin
         fails++;
         $display("FAIL stall_resume: got rd_en=%b addr=%0d, want 1 and 0", mem_rd_en, mem_rd_addr);
      end
      to = 1;
      for (int c = 0; c < 200; c++) begin
         if (done) begin to = 0; break; end
         @(negedge clk);
      end
      tests++;
      if (to != 0) begin fails++; $display("FAIL stall_done: no done within budget"); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_mid_reset();
      int to;
      @(negedge clk);
      clear_mon(); mon_en = 1; rdy_mode = 0; rdy_fixed = 2'b11;
      fsz = 8'd4; cks = 3'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      to = 1;
      for (int c = 0; c < 200; c++) begin
         if (rels.size() == 2 && mem_rd_en) begin to = 0; break; end
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (to != 0 || {buf_release, mem_rd_en, mem_rd_addr, input_buffer_select, line_buffer_enable,
                      window_valid, busy, done} !== 16'd0) begin
         fails++;
         $display("FAIL midreset_outputs: reached=%0d rd=%b addr=%0d lbe=%b busy=%b, want reached and all 0",
                  1 - to, mem_rd_en, mem_rd_addr, line_buffer_enable, busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      mon_en = 0;
      tests++;
      if (done_cnt != 0 || rels.size() != 2 || busy !== 1'b0) begin
         fails++;
         $display("FAIL midreset_abort: got done=%0d releases=%0d busy=%b, want 0, 2, 0", done_cnt, rels.size(), busy);
      end
      test_full_pass("after_reset", 4, 3, 0, 4);
   endtask

   // Second start and input changes land mid-pass; the pass must stay W=4, k=3.
   task automatic test_start_ignored();
      fork
         test_full_pass("busy_start", 4, 3, 0, 4);
         begin
            repeat (15) @(negedge clk);
            fsz = 8'd2; cks = 3'd1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
   endtask

   initial begin
      test_reset();
      test_full_pass("w4_k3", 4, 3, 0, 4);
      test_full_pass("w4_k1", 4, 1, 0, 16);
      test_random_ready();
      test_stall();
      test_mid_reset();
      test_full_pass("w0", 0, 3, 0, 0);
      test_full_pass("k0", 5, 0, 0, 0);
      test_start_ignored();
      test_full_pass("k5_w3", 3, 5, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
